// File: rtl/imem_ftch_buf.sv
// ----------------------------------------------------------------------------
// imem_ftch_buf
//
// Elastic buffer on the instruction-memory -> fetch response channel.
// The imem side has no back-pressure of its own: it offers a packet with
// imem_ftch_vld. The buffer tells it whether there is room (imem_ftch_rdy).
// Any packet offered while the buffer is full is counted as an overflow and
// latched in a sticky error flag. The fetch side consumes the head packet
// with a normal valid/ready handshake. A single-cycle flush drops everything
// that is buffered, for branch redirects.
//
// Optional build macro:
//   IMEM_FTCH_BUF_BYPASS_EN - when defined, a packet arriving at an empty
//   buffer is presented to fetch in the same cycle. If fetch takes it, the
//   packet is never written. When undefined, there is no combinational path
//   from imem_ftch_* to ftch_*.
//
// Parameters:
//   PKT_W  packet width in bits
//   DEPTH  number of FIFO entries (power of two, >= 2)
//   CNT_W  occupancy count width (derived from DEPTH)
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          synchronous active-high reset
//   flush          drop all buffered packets this cycle
//   imem_ftch_vld  imem response valid
//   imem_ftch_pkt  imem response packet
//   imem_ftch_rdy  buffer not full (from registered state only)
//   ftch_vld       head packet available to fetch
//   ftch_pkt       head packet
//   ftch_rdy       fetch accepts head packet
//   count          current occupancy
//   ovfl_err       sticky overflow flag, cleared only by reset
// ----------------------------------------------------------------------------
module imem_ftch_buf #(
  parameter int unsigned PKT_W = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             imem_ftch_vld,
  input  logic [PKT_W-1:0] imem_ftch_pkt,
  output logic             imem_ftch_rdy,
  output logic             ftch_vld,
  output logic [PKT_W-1:0] ftch_pkt,
  input  logic             ftch_rdy,
  output logic [CNT_W-1:0] count,
  output logic             ovfl_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  // Storage and state
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovfl_q, ovfl_d;

  // Control
  logic full;
  logic empty;
  logic buf_vld;
  logic byp_vld;
  logic byp_take;
  logic push;
  logic wr_en;
  logic pop_buf;
  logic ovfl_set;

  // Full/empty come from the occupancy count, so pointer equality never
  // has to be disambiguated.
  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

  // Ready only looks at registered state. A pop in the same cycle does not
  // reopen the input, so a full buffer rejects the packet even while it drains.
  assign imem_ftch_rdy = ~full;

  assign buf_vld = ~empty & ~flush;

`ifdef IMEM_FTCH_BUF_BYPASS_EN
  // An empty buffer forwards the incoming packet straight to fetch.
  assign byp_vld  = empty & imem_ftch_vld & ~flush;
  assign ftch_pkt = byp_vld ? imem_ftch_pkt : mem_q[rd_ptr_q];
`else
  assign byp_vld  = 1'b0;
  assign ftch_pkt = mem_q[rd_ptr_q];
`endif

  assign ftch_vld = buf_vld | byp_vld;
  assign byp_take = byp_vld & ftch_rdy;

  assign push     = imem_ftch_vld & imem_ftch_rdy & ~flush;
  // A bypassed packet that fetch takes immediately is never stored.
  assign wr_en    = push & ~byp_take;
  assign pop_buf  = buf_vld & ftch_rdy;
  // A packet that arrives during a flush is dropped silently and is not
  // counted as an overflow.
  assign ovfl_set = imem_ftch_vld & ~imem_ftch_rdy & ~flush;

  assign count    = count_q;
  assign ovfl_err = ovfl_q;

  // Next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovfl_d   = ovfl_q | ovfl_set;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_buf) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, pop_buf})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. The data array is also cleared on reset, so ftch_pkt
  // reads as 0 right after reset and never shows stale X data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovfl_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovfl_q   <= ovfl_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= imem_ftch_pkt;
      end
    end
  end

endmodule

// File: tb/tb_imem_ftch_buf.sv
module tb_imem_ftch_buf;

  localparam int unsigned PKT_W = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             imem_ftch_vld = 1'b0;
  logic [PKT_W-1:0] imem_ftch_pkt = '0;
  logic             imem_ftch_rdy;
  logic             ftch_vld;
  logic [PKT_W-1:0] ftch_pkt;
  logic             ftch_rdy = 1'b0;
  logic [CNT_W-1:0] count;
  logic             ovfl_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the expected packet order, plus the sticky overflow flag
  logic [PKT_W-1:0] sb_q[$];
  int unsigned      m_cnt = 0;
  logic             m_ovfl = 1'b0;

  imem_ftch_buf #(
    .PKT_W(PKT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .imem_ftch_vld(imem_ftch_vld),
    .imem_ftch_pkt(imem_ftch_pkt),
    .imem_ftch_rdy(imem_ftch_rdy),
    .ftch_vld     (ftch_vld),
    .ftch_pkt     (ftch_pkt),
    .ftch_rdy     (ftch_rdy),
    .count        (count),
    .ovfl_err     (ovfl_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    imem_ftch_vld = 1'b0;
    ftch_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    m_cnt = 0;
    m_ovfl = 1'b0;
  endtask

  // One clock cycle: drive the inputs after the falling edge, check the outputs
  // before the next rising edge, then advance the model.
  task automatic step(input logic v, input logic [PKT_W-1:0] p, input logic r, input logic f);
    logic             exp_vld;
    logic             exp_rdy;
    logic             byp;
    logic [PKT_W-1:0] exp_pkt;
    @(negedge clk);
    imem_ftch_vld = v;
    imem_ftch_pkt = p;
    ftch_rdy = r;
    flush = f;
    #1;
    exp_rdy = (m_cnt != DEPTH);
    byp = 1'b0;
`ifdef IMEM_FTCH_BUF_BYPASS_EN
    byp = (m_cnt == 0) && v && !f;
`endif
    exp_vld = ((m_cnt != 0) && !f) || byp;
    check_val("imem_ftch_rdy", 64'(imem_ftch_rdy), 64'(exp_rdy));
    check_val("ftch_vld", 64'(ftch_vld), 64'(exp_vld));
    check_val("count", 64'(count), 64'(m_cnt));
    check_val("ovfl_err", 64'(ovfl_err), 64'(m_ovfl));
    if (exp_vld && ftch_vld) begin
      exp_pkt = byp ? p : sb_q[0];
      check_val("ftch_pkt", ftch_pkt, exp_pkt);
    end
    if (f) begin
      sb_q.delete();
    end else begin
      if (v && !exp_rdy) m_ovfl = 1'b1;
      if (exp_vld && r && !byp) void'(sb_q.pop_front());
      if (v && exp_rdy && !(byp && r)) sb_q.push_back(p);
    end
    m_cnt = sb_q.size();
  endtask

  initial begin
    // Reset, then idle
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);

    // Fill to full with fetch stalled, then drain in order
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    step(1'b1, 64'h33, 1'b0, 1'b0);
    step(1'b1, 64'h44, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Overflow while full, even with a pop in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, 64'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 64'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Continuous push/pop; pointers wrap several times. ovfl_err stays set.
    for (int i = 1; i <= 12; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with two packets buffered and a packet arriving
    do_reset();
    step(1'b1, 64'h01, 1'b0, 1'b0);
    step(1'b1, 64'h02, 1'b0, 1'b0);
    step(1'b1, 64'h99, 1'b1, 1'b1);
    step(1'b1, 64'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while ovfl_err is set leaves the flag unchanged
    for (int i = 0; i < 5; i++) step(1'b1, 64'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 64'h98, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Empty buffer, packet with fetch ready (same cycle or one cycle later)
    step(1'b1, 64'hAB, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a stream discards all entries
    step(1'b1, 64'hC1, 1'b0, 1'b0);
    step(1'b1, 64'hC2, 1'b0, 1'b0);
    step(1'b1, 64'hC3, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 64'hD1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
